// File: rtl/adc_ramp_checker_pkg.sv
// Shared types and helpers for the ADC readback ramp checker: sample modes,
// FSM states and the mode-to-width mapping.
package adc_ramp_checker_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    MODE_8B  = 2'd0,
    MODE_12B = 2'd1,
    MODE_16B = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The reserved encoding falls back to byte-wide samples.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_12B;
      2'd2:    return MODE_16B;
      default: return MODE_8B;
    endcase
  endfunction

  function automatic int unsigned mode_width(input mode_e m);
    case (m)
      MODE_12B: return 12;
      MODE_16B: return 16;
      default:  return 8;
    endcase
  endfunction

  function automatic logic [SAMPLE_W-1:0] mode_mask(input mode_e m);
    return SAMPLE_W'((32'd1 << mode_width(m)) - 32'd1);
  endfunction

endpackage

// File: rtl/adc_ramp_checker_if.sv
// Readback byte stream as drained from the sample FIFO by the USB read side.
interface adc_ramp_checker_if;
  logic       I_byte_valid;
  logic [7:0] I_byte;

  modport master (output I_byte_valid, output I_byte);
  modport slave  (input  I_byte_valid, input  I_byte);
endinterface

// File: rtl/adc_ramp_unpacker.sv
// Byte-to-sample unpacker: tracks the byte phase within a packing group and
// presents each completed sample combinationally with its global index.
module adc_ramp_unpacker
  import adc_ramp_checker_pkg::*;
#(
  parameter int pCOUNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    enable,
  input  mode_e                   mode,
  adc_ramp_checker_if.slave       bytes,
  output logic [SAMPLE_W-1:0]     sample_p0,
  output logic                    vld_p0,
  output logic [pCOUNT_WIDTH-1:0] index
);

  logic [1:0] phase;
  logic [7:0] b0;
  logic [3:0] b1_lo;
  logic       take;

  assign take = enable && bytes.I_byte_valid;

  always_comb begin
    sample_p0 = '0;
    vld_p0    = 1'b0;
    if (take) begin
      case (mode)
        MODE_12B: begin
          if (phase == 2'd1) begin
            sample_p0 = {4'h0, b0, bytes.I_byte[7:4]};
            vld_p0    = 1'b1;
          end else if (phase == 2'd2) begin
            sample_p0 = {4'h0, b1_lo, bytes.I_byte};
            vld_p0    = 1'b1;
          end
        end
        MODE_16B: begin
          if (phase == 2'd1) begin
            sample_p0 = {b0, bytes.I_byte};
            vld_p0    = 1'b1;
          end
        end
        default: begin
          sample_p0 = {8'h00, bytes.I_byte};
          vld_p0    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase <= 2'd0;
      index <= '0;
    end else if (take) begin
      case (mode)
        MODE_12B: phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        MODE_16B: phase <= (phase == 2'd1) ? 2'd0 : 2'd1;
        default:  phase <= 2'd0;
      endcase
      if (vld_p0) index <= index + 1'b1;
    end
  end

  // Partial-group bytes held until the completing byte arrives.
  always_ff @(posedge clk) begin
    if (take) begin
      if (phase == 2'd0) b0 <= bytes.I_byte;
      if (phase == 2'd1) b1_lo <= bytes.I_byte[3:0];
    end
  end

endmodule

// File: rtl/adc_ramp_checker.sv
// Ramp checker top: run-control FSM, per-channel seed/last tracking, ramp
// compare, saturating good/bad counters and first-mismatch capture.
module adc_ramp_checker
  import adc_ramp_checker_pkg::*;
#(
  parameter int pCHANNELS    = 1,
  parameter int pCOUNT_WIDTH = 32
) (
  input  logic                    clk_usb,
  input  logic                    reset,
  input  logic [1:0]              I_mode,
  input  logic                    I_start,
  input  logic [pCOUNT_WIDTH-1:0] I_expected_samples,
  adc_ramp_checker_if.slave       bytes,
  output logic                    O_busy,
  output logic                    O_done,
  output logic                    O_sample_valid,
  output logic [SAMPLE_W-1:0]     O_sample,
  output logic [1:0]              O_sample_channel,
  output logic                    O_error,
  output logic [pCOUNT_WIDTH-1:0] O_good_count,
  output logic [pCOUNT_WIDTH-1:0] O_bad_count,
  output logic [pCOUNT_WIDTH-1:0] O_first_err_index,
  output logic [SAMPLE_W-1:0]     O_first_err_expected,
  output logic [SAMPLE_W-1:0]     O_first_err_got,
  output logic                    O_first_err_valid
);

  function automatic logic [pCOUNT_WIDTH-1:0] sat_inc(input logic [pCOUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e                  state;
  mode_e                   mode_q;
  logic [pCOUNT_WIDTH-1:0] expected_q;
  logic [1:0]              chan;
  logic [3:0]              seeded;
  logic [SAMPLE_W-1:0]     last [4];

  logic                    enable;
  logic [SAMPLE_W-1:0]     sample_p0;
  logic                    vld_p0;
  logic [pCOUNT_WIDTH-1:0] index_p0;
  logic [SAMPLE_W-1:0]     want_p0;
  logic                    mismatch_p0;
  logic                    final_p0;

  // A byte coinciding with I_start belongs to neither the old nor the new run.
  assign enable = (state == ST_RUN) && !I_start;

  adc_ramp_unpacker #(.pCOUNT_WIDTH(pCOUNT_WIDTH)) u_unpacker (
    .clk       (clk_usb),
    .rst       (reset),
    .clear     (I_start),
    .enable    (enable),
    .mode      (mode_q),
    .bytes     (bytes),
    .sample_p0 (sample_p0),
    .vld_p0    (vld_p0),
    .index     (index_p0)
  );

  assign want_p0     = (last[chan] + 16'd1) & mode_mask(mode_q);
  assign mismatch_p0 = (sample_p0 != want_p0);
  assign final_p0    = (index_p0 == expected_q - 1'b1);

  // p0 -> registered outputs
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state                <= ST_IDLE;
      mode_q               <= MODE_8B;
      expected_q           <= '0;
      chan                 <= 2'd0;
      seeded               <= '0;
      O_busy               <= 1'b0;
      O_done               <= 1'b0;
      O_sample_valid       <= 1'b0;
      O_sample             <= '0;
      O_sample_channel     <= 2'd0;
      O_error              <= 1'b0;
      O_good_count         <= '0;
      O_bad_count          <= '0;
      O_first_err_index    <= '0;
      O_first_err_expected <= '0;
      O_first_err_got      <= '0;
      O_first_err_valid    <= 1'b0;
    end else begin
      O_sample_valid <= vld_p0;
      O_error        <= 1'b0;
      if (I_start) begin
        mode_q               <= decode_mode(I_mode);
        expected_q           <= I_expected_samples;
        chan                 <= 2'd0;
        seeded               <= '0;
        O_good_count         <= '0;
        O_bad_count          <= '0;
        O_first_err_index    <= '0;
        O_first_err_expected <= '0;
        O_first_err_got      <= '0;
        O_first_err_valid    <= 1'b0;
        if (I_expected_samples == '0) begin
          state  <= ST_DONE;
          O_busy <= 1'b0;
          O_done <= 1'b1;
        end else begin
          state  <= ST_RUN;
          O_busy <= 1'b1;
          O_done <= 1'b0;
        end
      end else if (vld_p0) begin
        O_sample         <= sample_p0;
        O_sample_channel <= chan;
        chan             <= (chan == 2'(pCHANNELS - 1)) ? 2'd0 : chan + 2'd1;
        seeded[chan]     <= 1'b1;
        if (seeded[chan]) begin
          if (mismatch_p0) begin
            O_bad_count <= sat_inc(O_bad_count);
            O_error     <= 1'b1;
            if (!O_first_err_valid) begin
              O_first_err_valid    <= 1'b1;
              O_first_err_index    <= index_p0;
              O_first_err_expected <= want_p0;
              O_first_err_got      <= sample_p0;
            end
          end else begin
            O_good_count <= sat_inc(O_good_count);
          end
        end
        if (final_p0) begin
          state  <= ST_DONE;
          O_busy <= 1'b0;
          O_done <= 1'b1;
        end
      end
    end
  end

  // Last value always follows the received sample so a glitch costs two errors at most.
  always_ff @(posedge clk_usb) begin
    if (vld_p0) last[chan] <= sample_p0;
  end

endmodule

// File: tb/tb_adc_ramp_checker.sv
// Directed bench for adc_ramp_checker: a single-channel and a two-channel
// instance share one byte stream; per-sample expectations go through queues.
module tb_adc_ramp_checker;

  typedef struct {
    logic [15:0] s;
    logic [1:0]  ch;
    logic        e;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  mode;
  logic [31:0] expected;
  logic        start_a, start_b;

  adc_ramp_checker_if bif ();

  logic        a_busy, a_done, a_sample_valid, a_error, a_ferr_valid;
  logic [15:0] a_sample, a_ferr_exp, a_ferr_got;
  logic [1:0]  a_chan;
  logic [31:0] a_good, a_bad, a_ferr_index;

  logic        b_busy, b_done, b_sample_valid, b_error, b_ferr_valid;
  logic [15:0] b_sample, b_ferr_exp, b_ferr_got;
  logic [1:0]  b_chan;
  logic [31:0] b_good, b_bad, b_ferr_index;

  int nvec = 0;
  int nmis = 0;
  exp_t qa[$];
  exp_t qb[$];

  adc_ramp_checker #(.pCHANNELS(1), .pCOUNT_WIDTH(32)) dut_a (
    .clk_usb(clk), .reset(reset), .I_mode(mode), .I_start(start_a),
    .I_expected_samples(expected), .bytes(bif),
    .O_busy(a_busy), .O_done(a_done), .O_sample_valid(a_sample_valid),
    .O_sample(a_sample), .O_sample_channel(a_chan), .O_error(a_error),
    .O_good_count(a_good), .O_bad_count(a_bad), .O_first_err_index(a_ferr_index),
    .O_first_err_expected(a_ferr_exp), .O_first_err_got(a_ferr_got),
    .O_first_err_valid(a_ferr_valid)
  );

  adc_ramp_checker #(.pCHANNELS(2), .pCOUNT_WIDTH(32)) dut_b (
    .clk_usb(clk), .reset(reset), .I_mode(mode), .I_start(start_b),
    .I_expected_samples(expected), .bytes(bif),
    .O_busy(b_busy), .O_done(b_done), .O_sample_valid(b_sample_valid),
    .O_sample(b_sample), .O_sample_channel(b_chan), .O_error(b_error),
    .O_good_count(b_good), .O_bad_count(b_bad), .O_first_err_index(b_ferr_index),
    .O_first_err_expected(b_ferr_exp), .O_first_err_got(b_ferr_got),
    .O_first_err_valid(b_ferr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic push_a(input logic [15:0] s, input logic [1:0] c, input logic e);
    exp_t x;
    x.s = s; x.ch = c; x.e = e;
    qa.push_back(x);
  endtask

  task automatic push_b(input logic [15:0] s, input logic [1:0] c, input logic e);
    exp_t x;
    x.s = s; x.ch = c; x.e = e;
    qb.push_back(x);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bif.I_byte_valid = 1'b1;
    bif.I_byte       = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bif.I_byte_valid = 1'b0;
    end
  endtask

  task automatic do_start(input bit on_b, input logic [1:0] m, input logic [31:0] n);
    @(negedge clk);
    bif.I_byte_valid = 1'b0;
    mode     = m;
    expected = n;
    if (on_b) start_b = 1'b1;
    else      start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_sample_valid) begin
      if (qa.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL a_unexpected_strobe got=%0h want=none", a_sample);
      end else begin
        e = qa.pop_front();
        chk("a_sample", a_sample, e.s);
        chk("a_channel", a_chan, e.ch);
        chk("a_error", a_error, e.e);
      end
    end
    if (b_sample_valid) begin
      if (qb.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL b_unexpected_strobe got=%0h want=none", b_sample);
      end else begin
        e = qb.pop_front();
        chk("b_sample", b_sample, e.s);
        chk("b_channel", b_chan, e.ch);
        chk("b_error", b_error, e.e);
      end
    end
  end

  initial begin
    logic [7:0]  b;
    logic [11:0] s0, s1;
    logic [15:0] v;

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mode = 2'd0; expected = '0;
    bif.I_byte_valid = 1'b0; bif.I_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_good", a_good, 0);
    chk("rst_ferr_valid", a_ferr_valid, 0);
    chk("rst_sample_valid", a_sample_valid, 0);
    chk("rst_b_busy", b_busy, 0);
    reset = 1'b0;

    // 8-bit ramp through the 0xFF -> 0x00 wrap, then bytes after done
    do_start(1'b0, 2'd0, 100);
    chk("t1_busy", a_busy, 1);
    for (int i = 0; i < 100; i++) begin
      b = 8'(8'hFE + i);
      push_a({8'h00, b}, 2'd0, 1'b0);
      send(b);
      if (i == 99) chk("t1_done_early", a_done, 0);
    end
    idle(1);
    chk("t1_done", a_done, 1);
    chk("t1_busy_fall", a_busy, 0);
    chk("t1_good", a_good, 99);
    chk("t1_bad", a_bad, 0);
    chk("t1_ferr_valid", a_ferr_valid, 0);
    for (int i = 0; i < 10; i++) send(8'h55);
    idle(2);
    chk("t5_after_done_good", a_good, 99);
    chk("t5_after_done_bad", a_bad, 0);

    // 12-bit packed ramp through 0xFFF -> 0x000
    do_start(1'b0, 2'd1, 12);
    for (int g = 0; g < 6; g++) begin
      s0 = 12'(12'hFFC + 2 * g);
      s1 = 12'(12'hFFC + 2 * g + 1);
      push_a({4'h0, s0}, 2'd0, 1'b0);
      push_a({4'h0, s1}, 2'd0, 1'b0);
      send(s0[11:4]);
      send({s0[3:0], s1[11:8]});
      send(s1[7:0]);
    end
    idle(1);
    chk("t2_done", a_done, 1);
    chk("t2_good", a_good, 11);
    chk("t2_bad", a_bad, 0);

    // single-byte glitch at sample 50
    do_start(1'b0, 2'd0, 100);
    for (int i = 0; i < 100; i++) begin
      b = (i == 50) ? 8'h00 : 8'(i);
      push_a({8'h00, b}, 2'd0, (i == 50 || i == 51));
      send(b);
    end
    idle(1);
    chk("t3_good", a_good, 97);
    chk("t3_bad", a_bad, 2);
    chk("t3_ferr_valid", a_ferr_valid, 1);
    chk("t3_ferr_index", a_ferr_index, 50);
    chk("t3_ferr_expected", a_ferr_exp, 16'h0032);
    chk("t3_ferr_got", a_ferr_got, 16'h0000);

    // two interleaved 16-bit channels
    do_start(1'b1, 2'd2, 64);
    for (int k = 0; k < 64; k++) begin
      v = (k % 2 == 1) ? 16'(16'h8000 + k / 2) : 16'(16'h1000 + k / 2);
      push_b(v, 2'(k % 2), 1'b0);
      send(v[15:8]);
      send(v[7:0]);
    end
    idle(1);
    chk("t4_done", b_done, 1);
    chk("t4_good", b_good, 62);
    chk("t4_bad", b_bad, 0);

    // zero-length run
    do_start(1'b0, 2'd0, 0);
    chk("t5_zero_done", a_done, 1);
    chk("t5_zero_busy", a_busy, 0);
    chk("t5_zero_ferr_cleared", a_ferr_valid, 0);
    idle(2);
    chk("t5_zero_done_sticky", a_done, 1);
    chk("t5_zero_good", a_good, 0);

    // count ends mid-group: sample 0x103's byte must be dropped
    do_start(1'b0, 2'd1, 3);
    push_a(16'h0100, 2'd0, 1'b0);
    push_a(16'h0101, 2'd0, 1'b0);
    push_a(16'h0102, 2'd0, 1'b0);
    send(8'h10); send(8'h01); send(8'h01);
    send(8'h10); send(8'h21); send(8'h03);
    idle(2);
    chk("t5_mid_group_done", a_done, 1);
    chk("t5_mid_group_good", a_good, 2);

    // restart mid-run with a byte on the start cycle
    do_start(1'b0, 2'd0, 100);
    for (int i = 0; i < 20; i++) begin
      push_a(16'(i), 2'd0, 1'b0);
      send(8'(i));
    end
    @(negedge clk);
    start_a = 1'b1; expected = 10; mode = 2'd0;
    bif.I_byte_valid = 1'b1; bif.I_byte = 8'h99;
    for (int j = 0; j < 10; j++) begin
      push_a(16'(16'h0040 + j), 2'd0, 1'b0);
      send(8'(8'h40 + j));
      if (j == 0) start_a = 1'b0;
    end
    idle(1);
    chk("t6_restart_done", a_done, 1);
    chk("t6_restart_good", a_good, 9);
    chk("t6_restart_bad", a_bad, 0);

    // reset mid-run with a start in the same cycle
    do_start(1'b0, 2'd0, 100);
    for (int i = 0; i < 10; i++) begin
      b = (i == 5) ? 8'hAA : 8'(i);
      push_a({8'h00, b}, 2'd0, (i == 5 || i == 6));
      send(b);
    end
    idle(1);
    chk("t6_pre_reset_bad", a_bad, 2);
    chk("t6_pre_reset_busy", a_busy, 1);
    reset = 1'b1; start_a = 1'b1;
    @(negedge clk);
    chk("t6_reset_busy", a_busy, 0);
    chk("t6_reset_done", a_done, 0);
    chk("t6_reset_good", a_good, 0);
    chk("t6_reset_bad", a_bad, 0);
    chk("t6_reset_ferr_valid", a_ferr_valid, 0);
    chk("t6_reset_ferr_got", a_ferr_got, 0);
    chk("t6_reset_sample", a_sample, 0);
    reset = 1'b0; start_a = 1'b0;
    @(negedge clk);
    chk("t6_start_with_reset_ignored", a_busy, 0);

    idle(3);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
